// File: rtl/graphics_pkg.sv
// Shared definitions for the draw sequencer: FSM state encoding, channel
// indices and the default set of channels that get a black-clear pass.
package graphics_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLR_GO   = 3'd1,
    CLR_WAIT = 3'd2,
    DRW_GO   = 3'd3,
    DRW_WAIT = 3'd4
  } state_e;

  localparam int CH_MONEY   = 0;
  localparam int CH_SELECT  = 1;
  localparam int CH_UPGRADE = 2;
  localparam int CH_AUX     = 3;

  // Only the selection highlight leaves residue that must be blacked out first.
  localparam logic [3:0] DEF_CLEAR_MASK = 4'b0010;

endpackage

// File: rtl/prio_encoder.sv
// Combinational lowest-index-wins priority encoder.
module prio_encoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the lowest set index is the last to assign.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Latches per-channel draw requests on the frame pulse and serves them one at
// a time, by fixed priority, through a go/done handshake with the pixel drawer.
import graphics_pkg::*;

module draw_sequencer #(
  parameter int               NUM_CH     = 4,
  parameter int               CH_W       = 2,
  parameter logic [NUM_CH-1:0] CLEAR_MASK = NUM_CH'(DEF_CLEAR_MASK),
  parameter int               TIMEOUT    = 1023,
  parameter int               TO_W       = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pulse,
  input  logic [NUM_CH-1:0] req,
  input  logic              draw_done,
  output logic              draw_go,
  output logic [CH_W-1:0]   draw_ch,
  output logic              draw_black,
  output logic              busy,
  output logic [NUM_CH-1:0] pending,
  output logic              timeout_err,
  output state_e            state_dbg
);

  // Handshake: draw_go is a one-cycle start strobe with draw_ch/draw_black
  // valid alongside it and held until completion; draw_done is a one-cycle
  // strobe honoured only in the *_WAIT states, never in the cycle of draw_go.

  state_e              state_q, state_d;
  logic [CH_W-1:0]     draw_ch_q, draw_ch_d;
  logic [NUM_CH-1:0]   pending_q, pending_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic                terr_q, terr_d;
  logic [NUM_CH-1:0]   clr_vec;
  logic [CH_W-1:0]     sel_idx;
  logic                sel_valid;
  logic                wd_expire;

  prio_encoder #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_prio (
    .vec_i   (pending_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign wd_expire = (TIMEOUT != 0) && (wd_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      draw_ch_q <= '0;
      pending_q <= '0;
      wd_q      <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      draw_ch_q <= draw_ch_d;
      pending_q <= pending_d;
      wd_q      <= wd_d;
      terr_q    <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    draw_ch_d = draw_ch_q;
    wd_d      = wd_q;
    terr_d    = terr_q;
    clr_vec   = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          draw_ch_d = sel_idx;
          state_d   = CLEAR_MASK[sel_idx] ? CLR_GO : DRW_GO;
        end
      end
      CLR_GO: begin
        state_d = CLR_WAIT;
        wd_d    = '0;
      end
      CLR_WAIT: begin
        if (draw_done) begin
          state_d = DRW_GO;
        end else if (wd_expire) begin
          terr_d             = 1'b1;
          clr_vec[draw_ch_q] = 1'b1;
          state_d            = IDLE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      DRW_GO: begin
        state_d = DRW_WAIT;
        wd_d    = '0;
      end
      DRW_WAIT: begin
        // A hung drawer abandons the request the same way a completion retires it.
        if (draw_done || wd_expire) begin
          clr_vec[draw_ch_q] = 1'b1;
          state_d            = IDLE;
          if (!draw_done) terr_d = 1'b1;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new request on the retiring channel wins over the clear.
    pending_d = (pending_q & ~clr_vec) | (pulse ? req : '0);
  end

  always_comb begin
    draw_go     = (state_q == CLR_GO) || (state_q == DRW_GO);
    draw_black  = (state_q == CLR_GO) || (state_q == CLR_WAIT);
    busy        = (state_q != IDLE);
    draw_ch     = draw_ch_q;
    pending     = pending_q;
    timeout_err = terr_q;
    state_dbg   = state_q;
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer: hand-computed cycle-by-cycle expectations
// plus a queue of expected {black, channel} draw commands.
import graphics_pkg::*;

module tb_draw_sequencer;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic              clock;
  logic              resetn;
  logic              pulse;
  logic [NUM_CH-1:0] req;
  logic              draw_done;
  logic              draw_go;
  logic [CH_W-1:0]   draw_ch;
  logic              draw_black;
  logic              busy;
  logic [NUM_CH-1:0] pending;
  logic              timeout_err;
  state_e            state_dbg;

  int n_vec = 0;
  int n_err = 0;
  logic [CH_W:0] exp_q[$];

  draw_sequencer #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .CLEAR_MASK (4'b0010),
    .TIMEOUT    (8),
    .TO_W       (4)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .pulse       (pulse),
    .req         (req),
    .draw_done   (draw_done),
    .draw_go     (draw_go),
    .draw_ch     (draw_ch),
    .draw_black  (draw_black),
    .busy        (busy),
    .pending     (pending),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic pulse_req(input logic [NUM_CH-1:0] r);
    pulse = 1'b1;
    req   = r;
    tick();
    pulse = 1'b0;
    req   = '0;
  endtask

  task automatic give_done();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
  endtask

  // scoreboard: every draw_go must match the next expected command
  always @(negedge clock) begin
    if (resetn && draw_go) begin
      if (exp_q.size() == 0) begin
        check("unexpected_go", 32'(draw_go), 32'd0);
      end else begin
        check("go_cmd", 32'({draw_black, draw_ch}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    resetn    = 1'b0;
    pulse     = 1'b0;
    req       = '0;
    draw_done = 1'b0;
    repeat (2) tick();
    check("rst_go",      32'(draw_go),     32'd0);
    check("rst_black",   32'(draw_black),  32'd0);
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_ch",      32'(draw_ch),     32'd0);
    check("rst_pending", 32'(pending),     32'd0);
    check("rst_terr",    32'(timeout_err), 32'd0);
    check("rst_state",   32'(state_dbg),   32'(IDLE));
    resetn = 1'b1;
    tick();

    // single request, no clear pass
    exp_q.push_back({1'b0, 2'd0});
    pulse_req(4'b0001);
    check("t1_pending", 32'(pending), 32'b0001);
    check("t1_nogo",    32'(draw_go), 32'd0);
    tick();
    check("t1_go",      32'(draw_go), 32'd1);
    repeat (4) tick();
    give_done();
    check("t1_pend_clr", 32'(pending), 32'd0);
    check("t1_idle",     32'(busy),    32'd0);

    // clear-then-draw on channel 1, with a done during CLR_GO to be ignored
    exp_q.push_back({1'b1, 2'd1});
    exp_q.push_back({1'b0, 2'd1});
    pulse_req(4'b0010);
    tick();
    check("t2_clr_go", 32'(draw_go), 32'd1);
    give_done();
    check("t2_clr_wait", 32'(state_dbg),  32'(CLR_WAIT));
    check("t2_black",    32'(draw_black), 32'd1);
    repeat (2) tick();
    give_done();
    check("t2_drw_go",   32'(state_dbg), 32'(DRW_GO));
    check("t2_pend_hold", 32'(pending),  32'b0010);
    tick();
    repeat (2) tick();
    give_done();
    check("t2_pend_clr", 32'(pending), 32'd0);

    // fixed priority without preemption: ch2, then ch0, then ch3
    exp_q.push_back({1'b0, 2'd2});
    exp_q.push_back({1'b0, 2'd0});
    exp_q.push_back({1'b0, 2'd3});
    pulse_req(4'b1100);
    tick();
    check("t3_first_ch", 32'(draw_ch), 32'd2);
    pulse_req(4'b0001);
    repeat (2) tick();
    give_done();
    check("t3_gap1_idle", 32'(busy),    32'd0);
    check("t3_pend1",     32'(pending), 32'b1001);
    tick();
    check("t3_go2", 32'(draw_go), 32'd1);
    tick();
    give_done();
    check("t3_gap2_idle", 32'(busy),    32'd0);
    check("t3_pend2",     32'(pending), 32'b1000);
    tick();
    check("t3_go3", 32'(draw_go), 32'd1);
    tick();
    give_done();
    check("t3_pend3", 32'(pending), 32'd0);

    // set wins over clear on the same bit
    exp_q.push_back({1'b0, 2'd2});
    exp_q.push_back({1'b0, 2'd2});
    pulse_req(4'b0100);
    repeat (3) tick();
    pulse     = 1'b1;
    req       = 4'b0100;
    draw_done = 1'b1;
    tick();
    pulse     = 1'b0;
    req       = '0;
    draw_done = 1'b0;
    check("t4_set_wins", 32'(pending), 32'b0100);
    check("t4_idle",     32'(busy),    32'd0);
    tick();
    check("t4_redraw", 32'(draw_go), 32'd1);
    tick();
    give_done();
    check("t4_pend_clr", 32'(pending), 32'd0);

    // watchdog: eight wait cycles with no done
    exp_q.push_back({1'b0, 2'd0});
    pulse_req(4'b0001);
    tick();
    tick();
    repeat (7) tick();
    check("t5_not_yet", 32'(timeout_err), 32'd0);
    check("t5_waiting", 32'(state_dbg),   32'(DRW_WAIT));
    tick();
    check("t5_terr",    32'(timeout_err), 32'd1);
    check("t5_pending", 32'(pending),     32'd0);
    check("t5_state",   32'(state_dbg),   32'(IDLE));
    exp_q.push_back({1'b0, 2'd3});
    pulse_req(4'b1000);
    tick();
    check("t5_recover_go", 32'(draw_go), 32'd1);
    tick();
    give_done();
    check("t5_recover_pend", 32'(pending),     32'd0);
    check("t5_terr_sticky",  32'(timeout_err), 32'd1);

    // asynchronous reset during DRW_WAIT
    exp_q.push_back({1'b0, 2'd0});
    pulse_req(4'b0001);
    tick();
    tick();
    #2 resetn = 1'b0;
    #1;
    check("t6_busy",  32'(busy),        32'd0);
    check("t6_go",    32'(draw_go),     32'd0);
    check("t6_pend",  32'(pending),     32'd0);
    check("t6_terr",  32'(timeout_err), 32'd0);
    check("t6_state", 32'(state_dbg),   32'(IDLE));
    tick();
    tick();
    resetn = 1'b1;
    tick();
    give_done();
    check("t6_late_done_busy", 32'(busy),    32'd0);
    check("t6_late_done_pend", 32'(pending), 32'd0);
    tick();
    check("t6_no_go", 32'(draw_go), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
